multi_cycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS-subset datapath. Sequences PC, IR, memory, ALU and register file over

---
 rtl/multi_cycle_ctrl_if.sv | 36 +++
 rtl/multi_cycle_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Bundle between the multi-cycle controller and its datapath: IR fields and flags in,
// every enable and mux select out. The controller takes the master side.
interface multi_cycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       retire;
  logic       illegal;
  logic       bus_err;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, retire, illegal, bus_err
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, retire, illegal, bus_err
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB sequencing,
// beq/bne resolution from the zero flag, and a bounded wait on the memory ready handshake.
module multi_cycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  multi_cycle_ctrl_if.master io_bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // Last count value a memory state may reach while still waiting.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;
  logic       r_illegal;
  logic       r_bus_err;
  logic       w_set_illegal;
  logic       w_set_bus_err;
  logic       w_mem_state;

  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_ir_we;
  logic       w_iord;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_reg_we;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_retire;

  function automatic logic f_funct_ok(input logic [5:0] f);
    case (f)
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A: f_funct_ok = 1'b1;
      default:                                          f_funct_ok = 1'b0;
    endcase
  endfunction

  function automatic state_t f_dispatch(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OP_RTYPE:       f_dispatch = f_funct_ok(f) ? S_R_EXEC : S_TRAP;
      OP_LW, OP_SW:   f_dispatch = S_MEM_ADDR;
      OP_BEQ, OP_BNE: f_dispatch = S_BRANCH;
      OP_J:           f_dispatch = S_JUMP;
      OP_ADDI, OP_ORI: f_dispatch = S_I_EXEC;
      default:        f_dispatch = S_TRAP;
    endcase
  endfunction

  always_comb begin
    w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_illegal  <= r_illegal | w_set_illegal;
      r_bus_err  <= r_bus_err | w_set_bus_err;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_set_illegal   = 1'b0;
    w_set_bus_err   = 1'b0;
    w_wait_cnt_next = '0;
    case (r_state)
      S_IDLE:      w_next = S_FETCH;
      S_FETCH:     if (io_bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        w_next        = f_dispatch(io_bus.opcode, io_bus.funct);
        w_set_illegal = (w_next == S_TRAP);
      end
      S_MEM_ADDR:  w_next = (io_bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (io_bus.mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: if (io_bus.mem_ready) w_next = S_FETCH;
      S_R_EXEC:    w_next = S_R_WB;
      S_R_WB:      w_next = S_FETCH;
      S_I_EXEC:    w_next = S_I_WB;
      S_I_WB:      w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_IDLE;
    endcase
    // A wait cycle at the limit traps; mem_ready in that same cycle takes the normal path above.
    if (w_mem_state && !io_bus.mem_ready) begin
      if (r_wait_cnt >= WAIT_LIMIT) begin
        w_next        = S_TRAP;
        w_set_bus_err = 1'b1;
      end else begin
        w_wait_cnt_next = r_wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_pc_we      = 1'b0;
    w_pc_src     = PC_SEQ;
    w_ir_we      = 1'b0;
    w_iord       = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_reg_we     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_RT;
    w_alu_op     = ALU_ADD;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_rd    = 1'b1;
        w_ir_we     = io_bus.mem_ready;
        w_pc_we     = io_bus.mem_ready;
        w_alu_src_b = SRCB_FOUR;
      end
      S_DECODE: w_alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        w_mem_rd = 1'b1;
        w_iord   = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_we     = 1'b1;
        w_mem_to_reg = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_wr = 1'b1;
        w_iord   = 1'b1;
        w_retire = io_bus.mem_ready;
      end
      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        w_reg_we  = 1'b1;
        w_reg_dst = 1'b1;
        w_retire  = 1'b1;
      end
      S_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = (io_bus.opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_I_WB: begin
        w_reg_we = 1'b1;
        w_retire = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_SUB;
        w_pc_src    = PC_BR;
        w_pc_we     = ((io_bus.opcode == OP_BEQ) && io_bus.zero) ||
                      ((io_bus.opcode == OP_BNE) && !io_bus.zero);
        w_retire    = 1'b1;
      end
      S_JUMP: begin
        w_pc_we  = 1'b1;
        w_pc_src = PC_JMP;
        w_retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign io_bus.pc_we      = w_pc_we;
  assign io_bus.pc_src     = w_pc_src;
  assign io_bus.ir_we      = w_ir_we;
  assign io_bus.iord       = w_iord;
  assign io_bus.mem_rd     = w_mem_rd;
  assign io_bus.mem_wr     = w_mem_wr;
  assign io_bus.reg_we     = w_reg_we;
  assign io_bus.reg_dst    = w_reg_dst;
  assign io_bus.mem_to_reg = w_mem_to_reg;
  assign io_bus.alu_src_a  = w_alu_src_a;
  assign io_bus.alu_src_b  = w_alu_src_b;
  assign io_bus.alu_op     = w_alu_op;
  assign io_bus.retire     = w_retire;
  assign io_bus.illegal    = r_illegal;
  assign io_bus.bus_err    = r_bus_err;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: random instruction stream with a latency-planning memory responder,
// scoreboarded per instruction against a step-table model, followed by trap and reset scenarios.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;
  localparam int unsigned TMO     = 4;
  localparam int          N_INSTR = 60;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  multi_cycle_ctrl_if bus();
  multi_cycle_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit sb_on = 1'b0;

  logic [15:0] exp_vec_q[$];
  int          exp_len_q[$];
  int          lat_q[$];
  logic [15:0] act_q[$];
  logic [15:0] m_exp_q[$];
  logic [5:0]  legal_f[7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};

  // Control vector: {pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg,
  //                  alu_src_a, alu_src_b, alu_op, retire}
  function automatic logic [15:0] mk(input logic pc_we, input logic [1:0] pc_src,
                                     input logic ir_we, input logic iord, input logic mem_rd,
                                     input logic mem_wr, input logic reg_we, input logic reg_dst,
                                     input logic m2r, input logic src_a, input logic [1:0] src_b,
                                     input logic [1:0] op, input logic ret);
    return {pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, m2r, src_a, src_b, op, ret};
  endfunction

  function automatic logic [15:0] act_vec();
    return {bus.pc_we, bus.pc_src, bus.ir_we, bus.iord, bus.mem_rd, bus.mem_wr, bus.reg_we,
            bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.retire};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [15:0] v, input int cnt);
    for (int k = 0; k < cnt; k++) exp_vec_q.push_back(v);
  endtask

  // Expected step trace of one instruction, memory waits expanded by the planned latencies.
  task automatic push_instr(input logic [5:0] op, input logic z, input int lf, input int ld,
                            input bit first);
    int start;
    start = exp_vec_q.size();
    if (first) put(16'h0000, 1);
    put(mk(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0), lf);
    put(mk(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0), 1);
    put(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0), 1);
    lat_q.push_back(lf);
    case (op)
      6'h23: begin
        put(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0), 1);
        put(mk(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), ld + 1);
        put(mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 1), 1);
        lat_q.push_back(ld);
      end
      6'h2B: begin
        put(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0), 1);
        put(mk(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0), ld);
        put(mk(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1), 1);
        lat_q.push_back(ld);
      end
      6'h04, 6'h05: put(mk((op == 6'h04) ? z : !z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1), 1);
      6'h02: put(mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1), 1);
      6'h08, 6'h0D: begin
        put(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, (op == 6'h0D) ? 2'b11 : 2'b00, 0), 1);
        put(mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1), 1);
      end
      default: begin
        put(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0), 1);
        put(mk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1), 1);
      end
    endcase
    exp_len_q.push_back(exp_vec_q.size() - start);
  endtask

  int m_len;
  int m_idx;
  logic [31:0] m_act;

  // Monitor: records every cycle, and on each retire pops and checks one instruction's trace.
  always @(negedge clk) begin
    if (sb_on) begin
      act_q.push_back(act_vec());
      if (bus.retire) begin
        if (exp_len_q.size() == 0) begin
          chk("sb_unexpected_retire", 32'(exp_len_q.size()), 32'd1);
        end else begin
          m_len = exp_len_q.pop_front();
          m_exp_q.delete();
          for (int i = 0; i < m_len; i++) m_exp_q.push_back(exp_vec_q.pop_front());
          m_idx = 0;
          for (int i = m_len - 1; i >= 0; i--) begin
            if (i >= act_q.size()) m_idx = i;
            else if (act_q[i] !== m_exp_q[i]) m_idx = i;
          end
          m_act = (m_idx < act_q.size()) ? 32'(act_q[m_idx]) : 32'hFFFF_FFFF;
          chk("instr_cycles", 32'(act_q.size()), 32'(m_len));
          chk($sformatf("instr_step%0d_ctrl", m_idx), m_act, 32'(m_exp_q[m_idx]));
          chk("sticky_flags_clear", 32'({bus.illegal, bus.bus_err}), 32'd0);
        end
        act_q.delete();
      end
    end
  end

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic async_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    int cyc, issued, wait_left, n_cnt, sel, lf, ld;
    bit need_new, first, active, done;
    logic [5:0] op;
    logic z;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'(act_vec()), 32'd0);
    chk("reset_flags", 32'({bus.illegal, bus.bus_err}), 32'd0);

    release_reset();
    sb_on = 1'b1;
    @(negedge clk);
    need_new = 1'b1; first = 1'b1; active = 1'b0; done = 1'b0;
    issued = 0; cyc = 0; wait_left = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (need_new && issued < N_INSTR) begin
        sel = $urandom_range(0, 8);
        case (sel)
          0, 1: op = 6'h00;
          2: op = 6'h23;
          3: op = 6'h2B;
          4: op = 6'h04;
          5: op = 6'h05;
          6: op = 6'h02;
          7: op = 6'h08;
          default: op = 6'h0D;
        endcase
        z  = 1'($urandom_range(0, 1));
        lf = $urandom_range(0, TMO - 1);
        ld = $urandom_range(0, TMO - 1);
        bus.opcode = op;
        bus.funct  = (op == 6'h00) ? legal_f[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
        bus.zero   = z;
        push_instr(op, z, lf, ld, first);
        issued++;
        need_new = 1'b0;
        first    = 1'b0;
      end
      if (bus.mem_rd || bus.mem_wr) begin
        if (!active) begin
          active    = 1'b1;
          wait_left = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        end
        if (wait_left == 0) begin
          bus.mem_ready = 1'b1;
          active        = 1'b0;
        end else begin
          bus.mem_ready = 1'b0;
          wait_left--;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus.retire) begin
        need_new = 1'b1;
        if (issued == N_INSTR) done = 1'b1;
      end
    end
    chk("sb_all_retired", 32'(done), 32'd1);
    @(posedge clk); #1;
    sb_on = 1'b0;
    chk("sb_drained", 32'(exp_len_q.size()), 32'd0);

    // Memory never answers in FETCH: trap after TMO wait cycles, then no way out.
    async_reset();
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    n_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_rd) n_cnt++;
    end
    chk("timeout_wait_cycles", 32'(n_cnt), 32'(TMO));
    chk("timeout_bus_err", 32'(bus.bus_err), 32'd1);
    chk("timeout_no_illegal", 32'(bus.illegal), 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    n_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (act_vec() != 16'h0000) n_cnt++;
    end
    chk("trap_no_exit", 32'(n_cnt), 32'd0);
    chk("bus_err_sticky", 32'(bus.bus_err), 32'd1);
    async_reset();
    chk("async_clear_bus_err", 32'(bus.bus_err), 32'd0);

    // Unsupported opcode.
    bus.opcode = 6'h3F; bus.funct = 6'h20; bus.mem_ready = 1'b1;
    release_reset();
    @(negedge clk);
    @(negedge clk);
    chk("fetch_ir_we", 32'(bus.ir_we), 32'd1);
    @(negedge clk);
    chk("decode_src_b", 32'(bus.alu_src_b), 32'd3);
    chk("decode_illegal_pending", 32'(bus.illegal), 32'd0);
    @(negedge clk);
    chk("bad_opcode_illegal", 32'(bus.illegal), 32'd1);
    chk("bad_opcode_trap_ctrl", 32'(act_vec()), 32'd0);
    repeat (3) @(negedge clk);
    chk("illegal_sticky", 32'(bus.illegal), 32'd1);
    async_reset();
    chk("async_clear_illegal", 32'(bus.illegal), 32'd0);

    // R-type with unsupported funct.
    bus.opcode = 6'h00; bus.funct = 6'h08;
    release_reset();
    repeat (4) @(negedge clk);
    chk("bad_funct_illegal", 32'(bus.illegal), 32'd1);
    chk("bad_funct_trap_ctrl", 32'(act_vec()), 32'd0);
    chk("bad_funct_no_bus_err", 32'(bus.bus_err), 32'd0);
    async_reset();

    // Reset asserted while a store waits in MEM_WRITE.
    bus.opcode = 6'h2B; bus.funct = 6'h11; bus.mem_ready = 1'b1;
    release_reset();
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_mem_wr", 32'(bus.mem_wr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("reset_abort_ctrl", 32'(act_vec()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_reset_ctrl", 32'(act_vec()), 32'd0);
    release_reset();
    @(negedge clk);
    chk("idle_after_reset", 32'(act_vec()), 32'd0);
    @(negedge clk);
    chk("fetch_after_reset", 32'(bus.mem_rd), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
